// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Owns the PC, requests instruction words from
//   instruction memory over a req/ready handshake, applies beq/bne/j
//   redirects and registers each fetched word into the IF/ID latch.
//
//   Ports
//     clk, reset                    clock, synchronous active-high reset
//     imem_addr/req/ready/rdata     instruction-memory handshake
//     stall                         downstream cannot take a new IF/ID entry
//     branch_eq/ne, zero            branch resolution from EX
//     branch_pc4, branch_offset     branch base (PC+4) and word offset
//     jump, jump_target             jump request and instr[25:0]
//     ifid_instr/pc4/valid          IF/ID latch
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   FETCH    | request outstanding at pc
//   HOLD     | word fetched while stalled, parked in buf_q; no request
//   DROP     | redirected while a request was pending; finish it, discard
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        zero,
   input  logic [31:0] branch_pc4,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] saved_tgt_q, saved_tgt_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic        taken;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign taken    = (branch_eq & zero) | (branch_ne & ~zero);
   assign redirect = jump | taken;
   // jump takes priority over a simultaneously resolved branch
   assign target   = jump ? {branch_pc4[31:28], jump_target, 2'b00}
                          : branch_pc4 + (branch_offset << 2);
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_d        = buf_q;
      saved_tgt_d  = saved_tgt_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;

      // a redirect flushes IF/ID regardless of stall or state
      if (redirect) begin
         ifid_instr_d = 32'h0;
         ifid_pc4_d   = 32'h0;
         ifid_valid_d = 1'b0;
      end

      case (state_q)
         ST_FETCH: begin
            if (redirect) begin
               if (imem_ready) begin
                  pc_d = target;
               end else begin
                  // the pending request must complete at the old address
                  saved_tgt_d = target;
                  state_d     = ST_DROP;
               end
            end else if (imem_ready) begin
               if (stall) begin
                  buf_d   = imem_rdata;
                  state_d = ST_HOLD;
               end else begin
                  ifid_instr_d = imem_rdata;
                  ifid_pc4_d   = pc_plus4;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_plus4;
               end
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = ST_FETCH;
            end else if (!stall) begin
               ifid_instr_d = buf_q;
               ifid_pc4_d   = pc_plus4;
               ifid_valid_d = 1'b1;
               pc_d         = pc_plus4;
               state_d      = ST_FETCH;
            end
         end
         ST_DROP: begin
            if (redirect) begin
               saved_tgt_d = target;
            end
            if (imem_ready) begin
               pc_d    = redirect ? target : saved_tgt_q;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         buf_q        <= 32'h0;
         saved_tgt_q  <= 32'h0;
         ifid_instr_q <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_q        <= buf_d;
         saved_tgt_q  <= saved_tgt_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   // request is masked during the reset cycle itself
   assign imem_req   = ~reset & ((state_q == ST_FETCH) | (state_q == ST_DROP));
   assign imem_addr  = {pc_q[31:2], 2'b00};
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc4   = ifid_pc4_q;
   assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_eq;
   logic        branch_ne;
   logic        zero;
   logic [31:0] branch_pc4;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_target;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .stall(stall),
      .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
      .branch_pc4(branch_pc4), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory contents are a fixed function of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
   endfunction

   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   // reference model: fetch pointer, a parked word, a pending discard
   logic [31:0] m_pc, m_buf, m_saved, m_instr, m_pc4;
   bit          m_valid, m_hold, m_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic deliver(input logic [31:0] w);
      m_instr = w;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
   endtask

   task automatic model_step();
      bit          redir;
      logic [31:0] tgt;
      if (reset) begin
         m_pc = RESET_PC; m_buf = 0; m_saved = 0;
         m_instr = 0; m_pc4 = 0; m_valid = 0; m_hold = 0; m_drop = 0;
         return;
      end
      redir = jump || (branch_eq && zero) || (branch_ne && !zero);
      tgt   = jump ? {branch_pc4[31:28], jump_target, 2'b00}
                   : branch_pc4 + branch_offset * 32'd4;
      if (redir) begin
         m_valid = 0;
         m_instr = 0;
      end
      if (m_drop) begin
         if (redir) m_saved = tgt;
         if (imem_ready) begin
            m_pc   = m_saved;
            m_drop = 0;
         end
      end else if (m_hold) begin
         if (redir) begin
            m_pc   = tgt;
            m_hold = 0;
         end else if (!stall) begin
            deliver(m_buf);
            m_hold = 0;
         end
      end else begin
         if (redir) begin
            if (imem_ready) m_pc = tgt;
            else begin
               m_saved = tgt;
               m_drop  = 1;
            end
         end else if (imem_ready) begin
            if (stall) begin
               m_buf  = mem_word(m_pc);
               m_hold = 1;
            end else begin
               deliver(mem_word(m_pc));
            end
         end
      end
   endtask

   // compare process: outputs against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_req;
         exp_req = !reset && !m_hold;
         chk("req", {31'b0, imem_req}, {31'b0, exp_req});
         if (exp_req) chk("addr", imem_addr, m_pc);
         chk("valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         chk("instr", ifid_instr, m_instr);
         if (m_valid) chk("pc4", ifid_pc4, m_pc4);
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_redirect();
      branch_eq = 0; branch_ne = 0; zero = 0; jump = 0;
   endtask

   initial begin
      reset = 1; imem_ready = 0; stall = 0;
      branch_eq = 0; branch_ne = 0; zero = 0; jump = 0;
      branch_pc4 = 0; branch_offset = 0; jump_target = 0;
      repeat (2) cycle();
      chk_en = 1'b1;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'd0);

      // sequential fetch, zero-wait
      reset = 0; imem_ready = 1;
      #1;
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_req", {31'b0, imem_req}, 32'd1);
      cycle();
      chk("t1_valid", {31'b0, ifid_valid}, 32'd1);
      chk("t1_pc4_4", ifid_pc4, 32'h4);
      chk("t1_instr0", ifid_instr, mem_word(32'h0));
      chk("t1_addr4", imem_addr, 32'h4);
      cycle();
      chk("t1_pc4_8", ifid_pc4, 32'h8);

      // wait states at addr 8
      imem_ready = 0;
      repeat (3) begin
         cycle();
         chk("t2_addr8", imem_addr, 32'h8);
         chk("t2_pc4_held", ifid_pc4, 32'h8);
      end
      imem_ready = 1;
      cycle();
      chk("t2_pc4_12", ifid_pc4, 32'hC);
      chk("t2_addr12", imem_addr, 32'hC);

      // stall at addr 12
      stall = 1;
      cycle();
      chk("t3_req0", {31'b0, imem_req}, 32'd0);
      cycle();
      chk("t3_pc4_held", ifid_pc4, 32'hC);
      stall = 0;
      cycle();
      chk("t3_instr12", ifid_instr, mem_word(32'hC));
      chk("t3_addr16", imem_addr, 32'h10);

      // beq taken under stall, then bne not taken
      branch_eq = 1; zero = 1; branch_pc4 = 32'h20; branch_offset = -32'sd2; stall = 1;
      cycle();
      chk("t4_addr18", imem_addr, 32'h18);
      chk("t4_flush", {31'b0, ifid_valid}, 32'd0);
      clear_redirect(); stall = 0;
      cycle();
      branch_ne = 1; zero = 1;
      cycle();
      chk("t4_bne_addr", imem_addr, 32'h20);
      chk("t4_bne_valid", {31'b0, ifid_valid}, 32'd1);
      clear_redirect();

      // jump wins over beq, redirect during wait state
      jump = 1; branch_eq = 1; zero = 1; jump_target = 26'h40;
      branch_pc4 = 32'h20; branch_offset = 32'd1; imem_ready = 0;
      cycle();
      chk("t5_addr_held", imem_addr, 32'h20);
      clear_redirect();
      cycle();
      chk("t5_addr_held2", imem_addr, 32'h20);
      imem_ready = 1;
      cycle();
      chk("t5_addr100", imem_addr, 32'h100);
      jump = 1; branch_eq = 1; zero = 1; jump_target = 26'h80;
      cycle();
      chk("t5_jump_wins", imem_addr, 32'h200);
      clear_redirect();

      // reset during DROP
      branch_eq = 1; zero = 1; branch_pc4 = 32'h40; branch_offset = 32'd4; imem_ready = 0;
      cycle();
      clear_redirect();
      reset = 1;
      cycle();
      reset = 0;
      #1;
      chk("t6_drop_rst_addr", imem_addr, RESET_PC);
      chk("t6_drop_rst_valid", {31'b0, ifid_valid}, 32'd0);
      imem_ready = 1;
      cycle();
      chk("t6_drop_rst_next", imem_addr, RESET_PC + 32'h4);

      // reset during HOLD
      stall = 1;
      cycle();
      reset = 1;
      cycle();
      reset = 0; stall = 0;
      #1;
      chk("t6_hold_rst_addr", imem_addr, RESET_PC);
      chk("t6_hold_rst_req", {31'b0, imem_req}, 32'd1);
      cycle();
      chk("t6_hold_rst_pc4", ifid_pc4, RESET_PC + 32'h4);

      // PC wrap
      jump = 1; branch_pc4 = 32'hF000_0000; jump_target = 26'h3FF_FFFF;
      cycle();
      chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
      clear_redirect();
      cycle();
      chk("t6_wrap_addr", imem_addr, 32'h0);
      chk("t6_wrap_pc4", ifid_pc4, 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r;
         int          off;
         reset      = ($urandom_range(0, 99) == 0);
         imem_ready = ($urandom_range(0, 9) < 7);
         stall      = ($urandom_range(0, 3) == 0);
         branch_eq  = ($urandom_range(0, 9) == 0);
         branch_ne  = ($urandom_range(0, 9) == 0);
         zero       = $urandom_range(0, 1);
         jump       = ($urandom_range(0, 14) == 0);
         r          = $urandom;
         branch_pc4 = {r[31:2], 2'b00};
         off        = $urandom_range(0, 255) - 128;
         branch_offset = off;
         r          = $urandom;
         jump_target = r[25:0];
         cycle();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
